// File: rtl/cpu_types_pkg.sv
// Shared CPU encodings: opcodes, functs, ALU operations and the
// multi-cycle controller's state and control-bundle types.
package cpu_types_pkg;
   localparam int REG_W   = 5;
   localparam int SHAM_W  = 5;
   localparam int JADDR_W = 26;

   typedef logic [REG_W-1:0] regbits_t;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
      OP_BNE   = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
      OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E, OP_LUI  = 6'h0F,
      OP_LW    = 6'h23, OP_SW   = 6'h2B, OP_HALT  = 6'h3F
   } opcode_t;

   typedef enum logic [5:0] {
      FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08, FN_ADD  = 6'h20,
      FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
      FN_OR  = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT  = 6'h2A,
      FN_SLTU = 6'h2B
   } funct_t;

   typedef enum logic [3:0] {
      ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
      ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
   } aluop_t;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALTED} mc_state_t;

   localparam logic [1:0] PCSEL_PC4    = 2'd0;
   localparam logic [1:0] PCSEL_BRANCH = 2'd1;
   localparam logic [1:0] PCSEL_JUMP   = 2'd2;
   localparam logic [1:0] PCSEL_RS     = 2'd3;

   localparam logic [1:0] ALUSRC_RT    = 2'd0;
   localparam logic [1:0] ALUSRC_IMM   = 2'd1;
   localparam logic [1:0] ALUSRC_SHAMT = 2'd2;

   localparam logic [1:0] EXT_ZERO = 2'd0;
   localparam logic [1:0] EXT_SIGN = 2'd1;
   localparam logic [1:0] EXT_LUI  = 2'd2;

   localparam logic [1:0] WBSEL_ALU   = 2'd0;
   localparam logic [1:0] WBSEL_DLOAD = 2'd1;
   localparam logic [1:0] WBSEL_PC4   = 2'd2;

   localparam logic [1:0] DST_RD  = 2'd0;
   localparam logic [1:0] DST_RT  = 2'd1;
   localparam logic [1:0] DST_R31 = 2'd2;

   typedef struct packed {
      aluop_t     alu_op;
      logic [1:0] alu_src;
      logic [1:0] extnd_op;
      logic       legal;
   } ctrl_t;
endpackage

// File: rtl/mc_control_unit_if.sv
// Bundle of the multi-cycle control unit's signals with controller and bench views.
interface mc_control_unit_if
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 32
) (
   input logic CLK
);
   logic              nRST;
   logic [WORD_W-1:0] instruction;
   logic              ihit, dhit, zero;
   logic              iren, dren, dwen, irWen, pcWen;
   logic [1:0]        pcSel;
   aluop_t            aluOp;
   logic [1:0]        aluSrc, extndOp, memToRegSel, instrType;
   regbits_t          rs, rt, rd;
   logic [WORD_W-1:0] imm;
   logic [SHAM_W-1:0] shamt;
   logic [JADDR_W-1:0] jump;
   logic              wen, halt, err;
   logic [CNT_W-1:0]  retired;

   modport cu (
      input  CLK, nRST, instruction, ihit, dhit, zero,
      output iren, dren, dwen, irWen, pcWen, pcSel, aluOp, aluSrc, extndOp,
             memToRegSel, instrType, rs, rt, rd, imm, shamt, jump, wen, halt, err, retired
   );

   modport tb (
      input  CLK, iren, dren, dwen, irWen, pcWen, pcSel, aluOp, aluSrc, extndOp,
             memToRegSel, instrType, rs, rt, rd, imm, shamt, jump, wen, halt, err, retired,
      output nRST, instruction, ihit, dhit, zero
   );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decode into the ALU control bundle used in EXEC, MEM and WB.
module mc_ctrl_decode
   import cpu_types_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   output ctrl_t      ctrl_o
);
   always_comb begin
      ctrl_o = '{alu_op: ALU_ADD, alu_src: ALUSRC_RT, extnd_op: EXT_ZERO, legal: 1'b1};
      case (op_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_SLL:          begin ctrl_o.alu_op = ALU_SLL; ctrl_o.alu_src = ALUSRC_SHAMT; end
               FN_SRL:          begin ctrl_o.alu_op = ALU_SRL; ctrl_o.alu_src = ALUSRC_SHAMT; end
               FN_ADD, FN_ADDU: ctrl_o.alu_op = ALU_ADD;
               FN_SUB, FN_SUBU: ctrl_o.alu_op = ALU_SUB;
               FN_AND:          ctrl_o.alu_op = ALU_AND;
               FN_OR:           ctrl_o.alu_op = ALU_OR;
               FN_XOR:          ctrl_o.alu_op = ALU_XOR;
               FN_NOR:          ctrl_o.alu_op = ALU_NOR;
               FN_SLT:          ctrl_o.alu_op = ALU_SLT;
               FN_SLTU:         ctrl_o.alu_op = ALU_SLTU;
               FN_JR:           ;
               default:         ctrl_o.legal = 1'b0;
            endcase
         end
         OP_J, OP_JAL, OP_HALT: ;
         OP_BEQ, OP_BNE: ctrl_o.alu_op = ALU_SUB;
         OP_ADDIU, OP_LW, OP_SW: begin
            ctrl_o.alu_src  = ALUSRC_IMM;
            ctrl_o.extnd_op = EXT_SIGN;
         end
         OP_SLTI:  begin ctrl_o.alu_op = ALU_SLT;  ctrl_o.alu_src = ALUSRC_IMM; ctrl_o.extnd_op = EXT_SIGN; end
         OP_SLTIU: begin ctrl_o.alu_op = ALU_SLTU; ctrl_o.alu_src = ALUSRC_IMM; ctrl_o.extnd_op = EXT_SIGN; end
         OP_ANDI:  begin ctrl_o.alu_op = ALU_AND;  ctrl_o.alu_src = ALUSRC_IMM; end
         OP_ORI:   begin ctrl_o.alu_op = ALU_OR;   ctrl_o.alu_src = ALUSRC_IMM; end
         OP_XORI:  begin ctrl_o.alu_op = ALU_XOR;  ctrl_o.alu_src = ALUSRC_IMM; end
         // LUI: upper-placed immediate OR'd with $0
         OP_LUI:   begin ctrl_o.alu_op = ALU_OR;   ctrl_o.alu_src = ALUSRC_IMM; ctrl_o.extnd_op = EXT_LUI; end
         default:  ctrl_o.legal = 1'b0;
      endcase
   end
endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: instruction register, sequencing FSM, memory-wait timeout
// and retired-instruction counter.
//   state  | meaning
//   FETCH  | request icache, load IR and PC+4 on ihit
//   DECODE | resolve J/JAL/JR/HALT, otherwise go to EXEC
//   EXEC   | ALU operation; branches resolve here
//   MEM    | hold dren/dwen until dhit
//   WB     | register file write
//   HALTED | terminal until reset; halt=1, enables off
module mc_control_unit
   import cpu_types_pkg::*;
#(
   parameter int WORD_W      = 32,
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 32
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic [WORD_W-1:0]  instruction,
   input  logic               ihit,
   input  logic               dhit,
   input  logic               zero,
   output logic               iren,
   output logic               dren,
   output logic               dwen,
   output logic               irWen,
   output logic               pcWen,
   output logic [1:0]         pcSel,
   output aluop_t             aluOp,
   output logic [1:0]         aluSrc,
   output logic [1:0]         extndOp,
   output logic [1:0]         memToRegSel,
   output logic [1:0]         instrType,
   output regbits_t           rs,
   output regbits_t           rt,
   output regbits_t           rd,
   output logic [WORD_W-1:0]  imm,
   output logic [SHAM_W-1:0]  shamt,
   output logic [JADDR_W-1:0] jump,
   output logic               wen,
   output logic               halt,
   output logic               err,
   output logic [CNT_W-1:0]   retired
);
   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   mc_state_t         state_q, state_d;
   logic [WORD_W-1:0] ir_q;
   logic [CNT_W-1:0]  retired_q;
   logic [WAIT_W-1:0] waitcnt_q, waitcnt_d, wait_inc;
   logic              err_q, err_d, retire, wait_tc;
   logic [5:0]        op, funct;
   ctrl_t             ctrl;

   assign op    = ir_q[31:26];
   assign funct = ir_q[5:0];
   assign rs    = ir_q[25:21];
   assign rt    = ir_q[20:16];
   assign rd    = ir_q[15:11];
   assign shamt = ir_q[10:6];
   assign jump  = ir_q[25:0];
   assign imm   = {{(WORD_W-16){1'b0}}, ir_q[15:0]};

   assign halt    = (state_q == HALTED);
   assign err     = err_q;
   assign retired = retired_q;

   assign wait_inc = waitcnt_q + WAIT_W'(1);
   assign wait_tc  = (MEM_TIMEOUT != 0) && (wait_inc == WAIT_W'(MEM_TIMEOUT));

   mc_ctrl_decode u_decode (.op_i(op), .funct_i(funct), .ctrl_o(ctrl));

   always_comb begin
      state_d     = state_q;
      waitcnt_d   = '0;
      err_d       = err_q;
      retire      = 1'b0;
      iren        = 1'b0;
      dren        = 1'b0;
      dwen        = 1'b0;
      irWen       = 1'b0;
      pcWen       = 1'b0;
      wen         = 1'b0;
      pcSel       = PCSEL_PC4;
      aluOp       = ALU_ADD;
      aluSrc      = ALUSRC_RT;
      extndOp     = EXT_ZERO;
      memToRegSel = WBSEL_ALU;
      instrType   = DST_RD;
      // ALU controls stay stable from EXEC through write-back
      if (state_q == EXEC || state_q == MEM || state_q == WB) begin
         aluOp   = ctrl.alu_op;
         aluSrc  = ctrl.alu_src;
         extndOp = ctrl.extnd_op;
      end
      case (state_q)
         FETCH: begin
            iren = 1'b1;
            if (ihit) begin
               irWen   = 1'b1;
               pcWen   = 1'b1;
               state_d = DECODE;
            end else if (wait_tc) begin
               state_d = HALTED;
               err_d   = 1'b1;
            end else begin
               waitcnt_d = wait_inc;
            end
         end
         DECODE: begin
            state_d = EXEC;
            case (op)
               OP_HALT: begin
                  state_d = HALTED;
                  retire  = 1'b1;
               end
               OP_J: begin
                  pcWen   = 1'b1;
                  pcSel   = PCSEL_JUMP;
                  state_d = FETCH;
                  retire  = 1'b1;
               end
               OP_JAL: begin
                  pcWen       = 1'b1;
                  pcSel       = PCSEL_JUMP;
                  wen         = 1'b1;
                  instrType   = DST_R31;
                  memToRegSel = WBSEL_PC4;
                  state_d     = FETCH;
                  retire      = 1'b1;
               end
               OP_RTYPE: begin
                  if (funct == FN_JR) begin
                     pcWen   = 1'b1;
                     pcSel   = PCSEL_RS;
                     state_d = FETCH;
                     retire  = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         EXEC: begin
            if (op == OP_BEQ || op == OP_BNE) begin
               pcWen   = ~(zero ^ (op == OP_BEQ));
               pcSel   = PCSEL_BRANCH;
               state_d = FETCH;
               retire  = 1'b1;
            end else if (op == OP_LW || op == OP_SW) begin
               state_d = MEM;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            dren = (op == OP_LW);
            dwen = (op == OP_SW);
            if (dhit) begin
               state_d = (op == OP_LW) ? WB : FETCH;
               retire  = (op == OP_SW);
            end else if (wait_tc) begin
               state_d = HALTED;
               err_d   = 1'b1;
            end else begin
               waitcnt_d = wait_inc;
            end
         end
         WB: begin
            wen         = ctrl.legal;
            memToRegSel = (op == OP_LW) ? WBSEL_DLOAD : WBSEL_ALU;
            instrType   = (op == OP_RTYPE) ? DST_RD : DST_RT;
            state_d     = FETCH;
            retire      = 1'b1;
         end
         HALTED: ;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= FETCH;
         ir_q      <= '0;
         retired_q <= '0;
         waitcnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         waitcnt_q <= waitcnt_d;
         err_q     <= err_d;
         if (irWen)  ir_q      <= instruction;
         if (retire) retired_q <= retired_q + CNT_W'(1);
      end
   end
endmodule
